// File: rtl/drop_anim_sequencer.sv
// rtl/drop_anim_sequencer.sv - falling-token animation sequencer between game FSM and VGA display
// Optional landing bounce is enabled by defining DROP_BOUNCE_EN.
module drop_anim_sequencer #(
    parameter int ROWS          = 6,
    parameter int COLS          = 7,
    parameter int TICKS_PER_ROW = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_col,
    input  logic [2:0] req_row,
    input  logic       req_player,
    input  logic       abort,
    output logic       anim_active,
    output logic [2:0] anim_col,
    output logic [2:0] anim_row,
    output logic       anim_player,
    output logic       done,
    output logic       err
);

    localparam int              TW        = (TICKS_PER_ROW > 1) ? $clog2(TICKS_PER_ROW) : 1;
    localparam logic [TW-1:0]   TICK_LAST = TW'(TICKS_PER_ROW - 1);
    localparam logic [TW-1:0]   TICK_ONE  = TW'(1);
    localparam logic [3:0]      COLS_L    = 4'(COLS);
    localparam logic [3:0]      ROWS_L    = 4'(ROWS);

`ifdef DROP_BOUNCE_EN
    localparam logic [TW-1:0]   HALF_LAST = TW'(TICKS_PER_ROW / 2 - 1);
    typedef enum logic [2:0] {S_IDLE, S_FALL, S_BOUNCE_UP, S_BOUNCE_DN, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_FALL, S_DONE} state_t;
`endif

    state_t        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    col_q, col_d;
    logic [2:0]    row_q, row_d;
    logic [2:0]    target_q, target_d;
    logic          player_q, player_d;
    logic          err_q, err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            tick_q   <= '0;
            col_q    <= '0;
            row_q    <= '0;
            target_q <= '0;
            player_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            col_q    <= col_d;
            row_q    <= row_d;
            target_q <= target_d;
            player_q <= player_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        col_d    = col_q;
        row_d    = row_q;
        target_d = target_q;
        player_d = player_q;
        err_d    = 1'b0;
        // abort wins over everything; the anim_* registers keep their last values
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        if ({1'b0, req_col} >= COLS_L || {1'b0, req_row} >= ROWS_L) begin
                            err_d = 1'b1;
                        end else begin
                            col_d    = req_col;
                            target_d = req_row;
                            player_d = req_player;
                            row_d    = '0;
                            tick_d   = '0;
                            state_d  = S_FALL;
                        end
                    end
                end
                S_FALL: begin
                    if (frame_tick) begin
                        tick_d = tick_q + TICK_ONE;
                        if (tick_q == TICK_LAST) begin
                            tick_d = '0;
                            if (row_q == target_q) begin
`ifdef DROP_BOUNCE_EN
                                if (target_q != 3'd0) begin
                                    row_d   = target_q - 3'd1;
                                    state_d = S_BOUNCE_UP;
                                end else begin
                                    state_d = S_DONE;
                                end
`else
                                state_d = S_DONE;
`endif
                            end else begin
                                row_d = row_q + 3'd1;
                            end
                        end
                    end
                end
`ifdef DROP_BOUNCE_EN
                S_BOUNCE_UP: begin
                    if (frame_tick) begin
                        tick_d = tick_q + TICK_ONE;
                        if (tick_q == HALF_LAST) begin
                            tick_d  = '0;
                            row_d   = target_q;
                            state_d = S_BOUNCE_DN;
                        end
                    end
                end
                S_BOUNCE_DN: begin
                    if (frame_tick) begin
                        tick_d = tick_q + TICK_ONE;
                        if (tick_q == HALF_LAST) begin
                            tick_d  = '0;
                            state_d = S_DONE;
                        end
                    end
                end
`endif
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready   = (state_q == S_IDLE) & ~abort & ~rst;
        anim_active = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
        err         = err_q;
        anim_col    = col_q;
        anim_row    = row_q;
        anim_player = player_q;
    end

endmodule

// File: doc/drop_anim_sequencer.md
# drop_anim_sequencer

Sequences the falling-token animation between the game FSM and the VGA display. It accepts one drop request at a time (column, landing row, player) through a valid/ready handshake, then steps `anim_row` down the board on `frame_tick`. When the token lands it pulses `done` so the FSM commits the token into `color_p0`/`color_p1`. It replaces ad-hoc animation counting inside the FSM and drives the display's `anim_*` inputs directly.

## Interface
Parameters:
- `ROWS`, default 6: board rows. Row 0 is the top, `ROWS-1` the bottom.
- `COLS`, default 7: board columns.
- `TICKS_PER_ROW`, default 4: `frame_tick` pulses spent on each row. Must be ≥2.

Ports:
- `clk`  in  1  VGA pixel clock; the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `frame_tick`  in  1  one-cycle pulse per frame.
- `req_valid`  in  1  drop request present.
- `req_ready`  out  1  sequencer can accept a request.
- `req_col`  in  3  target column.
- `req_row`  in  3  landing row.
- `req_player`  in  1  0 = player A, 1 = player B.
- `abort`  in  1  cancel any animation (new game / reset from FSM).
- `anim_active`  out  1  display draws the moving token.
- `anim_col`  out  3  moving token column.
- `anim_row`  out  3  moving token current row.
- `anim_player`  out  1  moving token colour.
- `done`  out  1  one-cycle pulse: token landed. `anim_col`/`anim_row`/`anim_player` hold the landing cell in this cycle.
- `err`  out  1  one-cycle pulse: request rejected (out of range).

## Operation
- States: IDLE, FALL, BOUNCE_UP and BOUNCE_DN (only with the macro), DONE.
- `req_ready` = (state == IDLE) & ~`abort` & ~`rst`. This is combinational.
- **IDLE:**
  - A handshake occurs when `req_valid` & `req_ready`.
  - If `req_col` ≥ COLS or `req_row` ≥ ROWS: the request is consumed, `err` pulses the next cycle, and the state stays IDLE.
  - Otherwise:
    - Latch `req_col`, `req_row` and `req_player`.
    - Set `anim_row` = 0 and tick count = 0.
    - Set `anim_active` = 1 and go to FALL.
- **FALL:**
  - Each `frame_tick` increments the tick count.
  - On the tick that completes `TICKS_PER_ROW` ticks, the tick count clears, then:
    - if `anim_row` == target, go to DONE (or BOUNCE_UP with the macro);
    - otherwise increment `anim_row`.
- **DONE:**
  - Lasts one cycle with `done` = 1 and `anim_active` still 1.
  - Next cycle: `anim_active` = 0, state IDLE.
- **abort:**
  - Takes effect in any state; has priority over `frame_tick` and the handshake.
  - Next cycle: state IDLE, `anim_active` = 0, no `done`.
  - `anim_col`/`anim_row`/`anim_player` keep their values.
- Widths: the tick counter is $clog2(TICKS_PER_ROW) bits. Row arithmetic never wraps, because the target is ≤ ROWS-1.

## Timing
- Reset values: state IDLE, `anim_active` 0, `anim_col` 0, `anim_row` 0, `anim_player` 0, `done` 0, `err` 0.
- Latency in FALL: `done` is asserted one cycle after the (target+1)·TICKS_PER_ROW-th `frame_tick` counted in FALL.
- A `frame_tick` in the accept cycle is not counted.
- `anim_row` changes one cycle after the qualifying `frame_tick`.
- The earliest new accept is the cycle after DONE.
- `req_valid` held during FALL stalls (no accept) until IDLE.
- `rst` asserted mid-animation: outputs return to reset values immediately (asynchronous).

## Configuration
- `DROP_BOUNCE_EN` defined:
  - After landing with target > 0, BOUNCE_UP shows target-1 for TICKS_PER_ROW/2 ticks.
  - BOUNCE_DN then shows target for TICKS_PER_ROW/2 ticks, then the state goes to DONE.
  - With target == 0 the bounce is skipped.
  - `abort` applies in bounce states.
- `DROP_BOUNCE_EN` undefined: the bounce states do not exist; FALL goes directly to DONE.

## Test plan
- **Normal drop:** TICKS_PER_ROW=4; request col 3, row 5, player 1 → `anim_row` steps 0..5. `done` is high for one cycle, one cycle after the 24th `frame_tick`, with `anim_col`=3, `anim_row`=5, `anim_player`=1. `anim_active`=0 on the next cycle.
- **Top-row drop:** row 0 → `done` one cycle after the 4th tick. With `DROP_BOUNCE_EN` there is no bounce.
- **Rejects:** `req_col`=7 → `err` pulses once, `anim_active` stays 0. `req_row`=6 → same.
- **Abort:** assert `abort` at `anim_row`=2 → IDLE next cycle, `anim_active`=0, `done` never asserted. Simultaneous `abort` + `req_valid` in IDLE → `req_ready`=0, request not taken.
- **Back-pressure:** hold `req_valid` during FALL → `req_ready`=0 throughout; the second request is accepted the cycle after `done`.
- **Bounce** (`DROP_BOUNCE_EN`, target 5) → `anim_row` sequence 0..5, 4 (2 ticks), 5 (2 ticks), then `done`. Async `rst` mid-FALL → all outputs 0 immediately.
